// File: rtl/total_alu.sv
// total_alu: 32-bit MIPS-style ALU with combinational ops and a 32-cycle MULTU/DIVU sequencer writing Hi/Lo
module total_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] Output
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t          state;
  logic            armed;
  logic [WIDTH-1:0] hi, lo, opa, opb, acc;
  logic [CW-1:0]   cnt;
  logic [WIDTH:0]  msum;
  logic [WIDTH+1:0] diff;
  logic            qbit, mdcode, go;
  logic [WIDTH-1:0] rem_n;
  always_comb begin
    mdcode = Signal == 6'd25 || Signal == 6'd27;
    go     = state == IDLE && mdcode && !armed;
    msum   = {1'b0, acc} + {1'b0, opb[0] ? opa : {WIDTH{1'b0}}};
    diff   = {1'b0, acc, opa[WIDTH-1]} - {2'b0, opb};
    qbit   = !diff[WIDTH+1];
    rem_n  = qbit ? diff[WIDTH-1:0] : {acc[WIDTH-2:0], opa[WIDTH-1]};
  end
  // MUL: acc holds the running high word, opb shifts out multiplier bits and in product bits.
  // DIV: acc holds the partial remainder, opa shifts out dividend bits and in quotient bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      armed <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      armed <= mdcode && (armed || go);
      if (go) begin
        state <= Signal == 6'd25 ? MUL : DIV;
        opa   <= dataA;
        opb   <= dataB;
        acc   <= '0;
        cnt   <= '0;
      end else if (state == MUL) begin
        acc <= msum[WIDTH:1];
        opb <= {msum[0], opb[WIDTH-1:1]};
        cnt <= cnt + 1'b1;
        if (&cnt) begin
          hi    <= msum[WIDTH:1];
          lo    <= {msum[0], opb[WIDTH-1:1]};
          state <= IDLE;
        end
      end else if (state == DIV) begin
        acc <= rem_n;
        opa <= {opa[WIDTH-2:0], qbit};
        cnt <= cnt + 1'b1;
        if (&cnt) begin
          hi    <= rem_n;
          lo    <= {opa[WIDTH-2:0], qbit};
          state <= IDLE;
        end
      end
    end
  end
  always_comb begin
    Output = '0;
    case (Signal)
      6'd36: Output = dataA & dataB;
      6'd37: Output = dataA | dataB;
      6'd32: Output = dataA + dataB;
      6'd34: Output = dataA - dataB;
      6'd42: Output = {{(WIDTH-1){1'b0}}, $signed(dataA) < $signed(dataB)};
      6'd0:  Output = dataA << dataB[CW-1:0];
      6'd2:  Output = dataA >> dataB[CW-1:0];
      6'd16: Output = hi;
      6'd18: Output = lo;
      default: Output = '0;
    endcase
  end
endmodule

// File: tb/tb_total_alu.sv
// tb_total_alu: directed table vectors for combinational codes plus hand sequences for MULTU/DIVU, busy and reset
module tb_total_alu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic [5:0]  Signal = '0;
  logic [31:0] Output;
  int tests = 0;
  int failed = 0;

  total_alu dut (
    .clk(clk),
    .reset(reset),
    .dataA(dataA),
    .dataB(dataB),
    .Signal(Signal),
    .Output(Output)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  sig;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] exp);
    tests++;
    if (Output !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, Output, exp);
    end
  endtask

  task automatic apply(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name);
    @(negedge clk);
    Signal = sig;
    dataA  = a;
    dataB  = b;
    @(posedge clk);
    #1 chk(name, exp);
  endtask

  task automatic rd(input logic [5:0] sig, input logic [31:0] exp, input string name);
    apply(sig, dataA, dataB, exp, name);
  endtask

  task automatic start(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Signal = sig;
    dataA  = a;
    dataB  = b;
  endtask

  initial begin
    vecs[0] = '{6'd36, 32'd12, 32'd10, 32'd8, "and"};
    vecs[1] = '{6'd37, 32'd12, 32'd10, 32'd14, "or"};
    vecs[2] = '{6'd32, 32'hFFFFFFFF, 32'd2, 32'd1, "add_wrap"};
    vecs[3] = '{6'd34, 32'd3, 32'd5, 32'hFFFFFFFE, "sub_wrap"};
    vecs[4] = '{6'd42, 32'hFFFFFFFF, 32'd1, 32'd1, "slt_neg"};
    vecs[5] = '{6'd42, 32'd1, 32'hFFFFFFFF, 32'd0, "slt_pos"};
    vecs[6] = '{6'd0, 32'd1, 32'd31, 32'h80000000, "sll31"};
    vecs[7] = '{6'd2, 32'h80000000, 32'd31, 32'd1, "srl31"};
    vecs[8] = '{6'd2, 32'hF0000000, 32'h00000024, 32'h0F000000, "srl_b4_0"};
    vecs[9] = '{6'd63, 32'd12, 32'd10, 32'd0, "other_code"};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd(6'd16, 32'd0, "reset_hi");
    rd(6'd18, 32'd0, "reset_lo");

    foreach (vecs[i]) apply(vecs[i].sig, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    // held DIVU with dataA changed mid-run: only one division, on the latched operands
    start(6'd27, 32'd100, 32'd7);
    @(posedge clk);
    #1 chk("divu_out0", 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    dataA = 32'd50;
    repeat (65) @(posedge clk);
    rd(6'd16, 32'd2, "div100_7_hi");
    rd(6'd18, 32'd14, "div100_7_lo");

    start(6'd27, 32'd5, 32'd0);
    repeat (35) @(posedge clk);
    rd(6'd16, 32'd5, "div0_hi");
    rd(6'd18, 32'hFFFFFFFF, "div0_lo");

    start(6'd27, 32'hFFFFFFFF, 32'd1);
    repeat (35) @(posedge clk);
    rd(6'd16, 32'd0, "divmax1_hi");
    rd(6'd18, 32'hFFFFFFFF, "divmax1_lo");

    start(6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (35) @(posedge clk);
    rd(6'd16, 32'hFFFFFFFE, "mulmax_hi");
    rd(6'd18, 32'd1, "mulmax_lo");

    start(6'd25, 32'd3, 32'd4);
    repeat (35) @(posedge clk);
    rd(6'd16, 32'd0, "mul3_4_hi");
    rd(6'd18, 32'd12, "mul3_4_lo");

    start(6'd27, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    rd(6'd18, 32'd12, "busy_lo_prior");
    apply(6'd32, 32'd20, 32'd22, 32'd42, "busy_add");
    repeat (30) @(posedge clk);
    rd(6'd18, 32'd14, "busy_done_lo");

    start(6'd27, 32'd100, 32'd7);
    repeat (15) @(posedge clk);
    @(negedge clk);
    Signal = 6'd0;
    reset  = 1'b1;
    rd(6'd18, 32'd0, "in_reset_lo");
    @(negedge clk);
    reset = 1'b0;
    rd(6'd16, 32'd0, "abort_hi");
    repeat (40) @(posedge clk);
    rd(6'd18, 32'd0, "abort_lo_stays");

    start(6'd27, 32'd9, 32'd2);
    repeat (35) @(posedge clk);
    rd(6'd16, 32'd1, "div9_2_hi");
    rd(6'd18, 32'd4, "div9_2_lo");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
